// File: rtl/mem_bus_resp_if.sv
// rtl/mem_bus_resp_if.sv - control-unit <-> memory responder strobe and bus bundle
//
// Signals:
//   memaddr_in  : latch bus_in into the responder address register
//   mem_req     : access request, held until mem_ready
//   mem_rw      : 1 = write (SB), 0 = read (LB), sampled with mem_req
//   memdata_out : drive the read-data register onto the bus
//   bus_in      : 16-bit datapath bus into the responder
//   bus_out     : 16-bit read data driven back (zero when not enabled)
//   bus_oe      : bus_out is being driven
//   mem_ready   : one-cycle completion pulse
//   mem_err     : out-of-range access flag, valid with mem_ready
// Modports: master = control unit side, slave = memory responder side.
interface mem_bus_resp_if;
  logic        memaddr_in;
  logic        mem_req;
  logic        mem_rw;
  logic        memdata_out;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output memaddr_in, mem_req, mem_rw, memdata_out, bus_in,
    input  bus_out, bus_oe, mem_ready, mem_err
  );

  modport slave (
    input  memaddr_in, mem_req, mem_rw, memdata_out, bus_in,
    output bus_out, bus_oe, mem_ready, mem_err
  );
endinterface

// File: rtl/mem_bus_resp.sv
// rtl/mem_bus_resp.sv - byte RAM responder with wait states and ready/error handshake
//
// Parameters:
//   DEPTH       : number of byte locations (valid addresses 0..DEPTH-1)
//   WAIT_CYCLES : wait states inserted before each access completes (0..15)
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_bus_resp_if.slave (address latch, request, read-data drive,
//           datapath bus, ready/error handshake)
module mem_bus_resp #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_bus_resp_if.slave   bus
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L   = 17'(DEPTH);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        op_q, op_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  rd_q, rd_d;
  logic        ready_q, err_q;
  logic        access;
  logic        in_range;
  logic        ram_we;
  logic [AW-1:0] ram_idx;

  logic [7:0] ram [DEPTH];

  // Full 16-bit compare so aliased high addresses are flagged, not wrapped.
  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign ram_idx  = addr_q[AW-1:0];

  // The access is performed on the edge entering DONE. With zero wait states
  // that is the accept edge itself, so op/wdata come from the *_d values,
  // which equal the captured values in every case.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.memaddr_in) begin
          addr_d = bus.bus_in;
        end else if (bus.mem_req) begin
          op_d    = bus.mem_rw;
          wdata_d = bus.bus_in[7:0];
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
            access  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_d = rd_q;
    if (access && !op_d) begin
      rd_d = in_range ? ram[ram_idx] : 8'hFF;
    end
  end

  // Gated by rst_n so an access can never land in the RAM while reset is held.
  assign ram_we = access && op_d && in_range && rst_n;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= 16'h0000;
      op_q    <= 1'b0;
      wdata_q <= 8'h00;
      cnt_q   <= 4'd0;
      rd_q    <= 8'h00;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      ready_q <= access;
      err_q   <= access && !in_range;
    end
  end

  assign bus.bus_out   = bus.memdata_out ? {8'h00, rd_q} : 16'h0000;
  assign bus.bus_oe    = bus.memdata_out;
  assign bus.mem_ready = ready_q;
  assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_mem_bus_resp.sv
// tb/tb_mem_bus_resp.sv - self-checking bench for mem_bus_resp (WAIT_CYCLES=2 and 0)
module tb_mem_bus_resp;

  localparam int DEPTH_A = 256;
  localparam int WAIT_A  = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_bus_resp_if ia();
  mem_bus_resp_if ib();

  mem_bus_resp #(.DEPTH(DEPTH_A), .WAIT_CYCLES(WAIT_A)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  mem_bus_resp #(.DEPTH(256), .WAIT_CYCLES(0)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    logic        exp_err;
    logic [15:0] exp_bus;
  } vec_t;

  vec_t vecs[9];

  // Behavioural model: a byte array plus "known" flags and the last read value.
  logic [7:0] m_mem [256];
  bit         m_known [256];
  logic [7:0] m_rd;
  bit         m_rd_known;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  function automatic bit model_access(input logic [15:0] addr, input logic rw,
                                      input logic [7:0] wd);
    bit inr;
    inr = (int'(addr) < DEPTH_A);
    if (rw) begin
      if (inr) begin
        m_mem[addr[7:0]]   = wd;
        m_known[addr[7:0]] = 1'b1;
      end
    end else if (inr) begin
      m_rd       = m_mem[addr[7:0]];
      m_rd_known = m_known[addr[7:0]];
    end else begin
      m_rd       = 8'hFF;
      m_rd_known = 1'b1;
    end
    return !inr;
  endfunction

  // One full access on DUT A: latch address, request, wait for ready, release.
  task automatic acc_a(input string nm, input logic [15:0] addr, input logic rw,
                       input logic [7:0] wd);
    int          lat;
    logic        err;
    logic [15:0] bo;
    bit          exp_err;
    ia.memaddr_in = 1'b1;
    ia.bus_in     = addr;
    tick();
    ia.memaddr_in = 1'b0;
    ia.mem_req    = 1'b1;
    ia.mem_rw     = rw;
    ia.bus_in     = {8'h00, wd};
    tick();
    lat = 0;
    while (!ia.mem_ready && lat < 20) begin
      tick();
      lat++;
    end
    err = ia.mem_err;
    bo  = ia.bus_out;
    ia.mem_req = 1'b0;
    tick();
    exp_err = model_access(addr, rw, wd);
    chk({nm, " latency"}, 32'(lat), 32'(WAIT_A));
    chk({nm, " err"}, 32'(err), 32'(exp_err));
    chk({nm, " ready_width"}, 32'({ia.mem_ready, ia.mem_err}), 32'd0);
    if (m_rd_known) chk({nm, " bus_out"}, 32'(bo), 32'({8'h00, m_rd}));
  endtask

  task automatic wr_b(input logic [15:0] addr, input logic [7:0] wd);
    ib.memaddr_in = 1'b1;
    ib.bus_in     = addr;
    tick();
    ib.memaddr_in = 1'b0;
    ib.mem_req    = 1'b1;
    ib.mem_rw     = 1'b1;
    ib.bus_in     = {8'h00, wd};
    tick();
    chk("b_write ready", 32'(ib.mem_ready), 32'd1);
    ib.mem_req = 1'b0;
    tick();
  endtask

  initial begin
    int pulses;
    checks = 0;
    errors = 0;
    m_rd = 8'h00;
    m_rd_known = 1'b1;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

    vecs[0] = '{16'h0012, 1'b1, 8'hA5, 1'b0, 16'h0000};
    vecs[1] = '{16'h0012, 1'b0, 8'h00, 1'b0, 16'h00A5};
    vecs[2] = '{16'h0000, 1'b1, 8'h33, 1'b0, 16'h00A5};
    vecs[3] = '{16'h0100, 1'b1, 8'h77, 1'b1, 16'h00A5};
    vecs[4] = '{16'h0100, 1'b0, 8'h00, 1'b1, 16'h00FF};
    vecs[5] = '{16'h0000, 1'b0, 8'h00, 1'b0, 16'h0033};
    vecs[6] = '{16'h0005, 1'b1, 8'h5A, 1'b0, 16'h0033};
    vecs[7] = '{16'h0005, 1'b0, 8'h00, 1'b0, 16'h005A};
    vecs[8] = '{16'hFFFF, 1'b0, 8'h00, 1'b1, 16'h00FF};

    rst_n = 1'b0;
    ia.memaddr_in = 1'b0; ia.mem_req = 1'b0; ia.mem_rw = 1'b0;
    ia.memdata_out = 1'b1; ia.bus_in = 16'h0000;
    ib.memaddr_in = 1'b0; ib.mem_req = 1'b0; ib.mem_rw = 1'b0;
    ib.memdata_out = 1'b1; ib.bus_in = 16'h0000;
    tick();
    tick();
    chk("reset ready", 32'(ia.mem_ready), 32'd0);
    chk("reset err", 32'(ia.mem_err), 32'd0);
    chk("reset bus_out", 32'(ia.bus_out), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      acc_a($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rw, vecs[i].wdata);
      chk($sformatf("vec%0d table_bus", i), 32'(ia.bus_out), 32'(vecs[i].exp_bus));
      chk($sformatf("vec%0d table_oe", i), 32'(ia.bus_oe), 32'd1);
    end

    // Reset in the middle of the wait of a write of 8'h3C to 0x05.
    ia.memaddr_in = 1'b1; ia.bus_in = 16'h0005;
    tick();
    ia.memaddr_in = 1'b0; ia.mem_req = 1'b1; ia.mem_rw = 1'b1; ia.bus_in = 16'h003C;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid ready", 32'(ia.mem_ready), 32'd0);
    chk("rst_mid err", 32'(ia.mem_err), 32'd0);
    chk("rst_mid bus_out", 32'(ia.bus_out), 32'd0);
    ia.mem_req = 1'b0;
    tick();
    rst_n = 1'b1;
    m_rd = 8'h00;
    tick();
    acc_a("after_rst read05", 16'h0005, 1'b0, 8'h00);
    chk("after_rst value", 32'(ia.bus_out), 32'h005A);

    ia.memdata_out = 1'b0;
    #1;
    chk("oe_off bus_out", 32'(ia.bus_out), 32'd0);
    chk("oe_off bus_oe", 32'(ia.bus_oe), 32'd0);
    ia.memdata_out = 1'b1;
    #1;

    // Address latch has priority over a simultaneous request.
    acc_a("pri_setup_w40", 16'h0040, 1'b1, 8'hC7);
    acc_a("pri_setup_r12", 16'h0012, 1'b0, 8'h00);
    ia.memaddr_in = 1'b1; ia.mem_req = 1'b1; ia.mem_rw = 1'b0; ia.bus_in = 16'h0040;
    tick();
    ia.memaddr_in = 1'b0; ia.bus_in = 16'h0000;
    pulses = 0;
    for (int i = 0; i < 3 && !ia.mem_ready; i++) begin
      tick();
      pulses++;
    end
    chk("pri ready_edges", 32'(pulses), 32'(WAIT_A + 1));
    chk("pri bus_out", 32'(ia.bus_out), 32'h00C7);
    ia.mem_req = 1'b0;
    tick();
    void'(model_access(16'h0040, 1'b0, 8'h00));

    // Request pulsed during the wait must not create another access.
    ia.mem_req = 1'b1; ia.mem_rw = 1'b0;
    tick();
    ia.mem_req = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) ia.mem_req = 1'b1;
      if (i == 2) ia.mem_req = 1'b0;
      tick();
      if (ia.mem_ready) pulses++;
    end
    chk("wait_pulse ready_count", 32'(pulses), 32'd1);
    void'(model_access(16'h0040, 1'b0, 8'h00));

    for (int i = 0; i < 80; i++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(256, 65535))
                                      : 16'($urandom_range(0, 15));
      acc_a($sformatf("rand%0d", i), a, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Zero wait states: back-to-back with mem_req held.
    wr_b(16'h0001, 8'h11);
    wr_b(16'h0002, 8'h22);
    ib.memaddr_in = 1'b1; ib.bus_in = 16'h0001;
    tick();
    ib.memaddr_in = 1'b0; ib.mem_req = 1'b1; ib.mem_rw = 1'b0;
    tick();
    chk("b2b e0 ready", 32'(ib.mem_ready), 32'd1);
    chk("b2b e0 bus", 32'(ib.bus_out), 32'h0011);
    tick();
    chk("b2b e1 ready", 32'(ib.mem_ready), 32'd0);
    tick();
    chk("b2b e2 ready", 32'(ib.mem_ready), 32'd1);
    tick();
    chk("b2b e3 ready", 32'(ib.mem_ready), 32'd0);
    ib.memaddr_in = 1'b1; ib.bus_in = 16'h0002;
    tick();
    chk("b2b e4 ready", 32'(ib.mem_ready), 32'd0);
    ib.memaddr_in = 1'b0;
    tick();
    chk("b2b e5 ready", 32'(ib.mem_ready), 32'd1);
    chk("b2b e5 bus", 32'(ib.bus_out), 32'h0022);
    ib.mem_req = 1'b0;
    tick();
    chk("b2b idle ready", 32'(ib.mem_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
